// File: rtl/axi_pmu_pkg.sv
// Counter index map and shared constants for the AXI performance monitor.
package axi_pmu_pkg;

  localparam int NUM_CNT = 23;
  localparam int NUM_EV  = 18;
  localparam int MAX_W   = 64;

  // Truncated to CNT_W at use; the minimum starts high so the first sample always wins.
  localparam logic [MAX_W-1:0] LAT_MIN_RST = '1;

  typedef enum logic [4:0] {
    CNT_RD_IDLE      = 5'd0,
    CNT_AR_STALL     = 5'd1,
    CNT_AR_HS        = 5'd2,
    CNT_RVALID_STALL = 5'd3,
    CNT_RREADY_STALL = 5'd4,
    CNT_R_HS         = 5'd5,
    CNT_LAT_SUM      = 5'd6,
    CNT_LAT_MAX      = 5'd7,
    CNT_LAT_MIN      = 5'd8,
    CNT_WR_IDLE      = 5'd9,
    CNT_AW_STALL     = 5'd10,
    CNT_AW_HS        = 5'd11,
    CNT_WVALID_STALL = 5'd12,
    CNT_WREADY_STALL = 5'd13,
    CNT_W_HS         = 5'd14,
    CNT_BVALID_STALL = 5'd15,
    CNT_BREADY_STALL = 5'd16,
    CNT_B_HS         = 5'd17,
    CNT_RD_OUT       = 5'd18,
    CNT_WR_OUT       = 5'd19,
    CNT_WR_LAT_SUM   = 5'd20,
    CNT_WR_LAT_MAX   = 5'd21,
    CNT_WR_LAT_MIN   = 5'd22
  } pmu_cnt_e;

endpackage

// File: rtl/axi_if.sv
// Handshake-level view of one AXI port; the mon modport only observes.
interface axi_if;
  logic arvalid;
  logic arready;
  logic rvalid;
  logic rready;
  logic rlast;
  logic awvalid;
  logic awready;
  logic wvalid;
  logic wready;
  logic wlast;
  logic bvalid;
  logic bready;

  modport mon (
    input arvalid, arready, rvalid, rready, rlast,
    input awvalid, awready, wvalid, wready, wlast, bvalid, bready
  );
endinterface

// File: rtl/axi_pmu_lat_tracker.sv
// Burst latency tracker: request pushes the timestamp, final response pops it; saturating sum/max/min.
// Stats update one cycle after the pop handshake; purely observing, never backpressures.
module axi_pmu_lat_tracker
  import axi_pmu_pkg::*;
#(
  parameter int CNT_W = 48,
  parameter int TS_W  = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic [TS_W-1:0]  ts,
  input  logic             push,
  input  logic             pop,
  output logic [CNT_W-1:0] lat_sum,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] lat_min,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int AW = $clog2(DEPTH);
  localparam int WW = (TS_W > CNT_W) ? TS_W : CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [TS_W-1:0]  mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;
  logic [TS_W-1:0]  lat;
  logic [WW-1:0]    lat_w;
  logic [CNT_W-1:0] lat_c;
  logic [CNT_W:0]   sum_ext;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full | do_pop);

  assign lat     = ts - mem[rptr];
  assign lat_w   = WW'(lat);
  assign lat_c   = (lat_w > WW'(CNT_MAX)) ? CNT_MAX : lat_w[CNT_W-1:0];
  assign sum_ext = {1'b0, lat_sum} + {1'b0, lat_c};

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= ts;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_sum <= '0;
      lat_max <= '0;
      lat_min <= LAT_MIN_RST[CNT_W-1:0];
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (push & full & ~do_pop) err_ovf <= 1'b1;
      if (pop & empty)           err_unf <= 1'b1;
      // After a dropped push the FIFO no longer pairs requests with responses.
      if (clear) begin
        lat_sum <= '0;
        lat_max <= '0;
        lat_min <= LAT_MIN_RST[CNT_W-1:0];
      end else if (en & do_pop & ~err_ovf) begin
        lat_sum <= sum_ext[CNT_W] ? CNT_MAX : sum_ext[CNT_W-1:0];
        if (lat_c > lat_max) lat_max <= lat_c;
        if (lat_c < lat_min) lat_min <= lat_c;
      end
    end
  end

endmodule

// File: rtl/axi_pmu_lat.sv
// AXI perf monitor: idle/stall/handshake counters, read latency stats, indexed readout (1-cycle latency).
// Passive observer, never backpressures. AXI_PMU_WR_LAT_EN adds the AW->B latency tracker (idx 20-22).
module axi_pmu_lat
  import axi_pmu_pkg::*;
#(
  parameter int CNT_W       = 48,
  parameter int TS_W        = 32,
  parameter int OUTST_DEPTH = 8,
  parameter int SEL_W       = 5
) (
  input  logic             aclk,
  input  logic             areset,
  axi_if.mon               mon_axi,
  input  logic             en,
  input  logic             clear,
  input  logic             snap,
  input  logic             snap_sel,
  input  logic [SEL_W-1:0] cnt_sel,
  output logic [CNT_W-1:0] cnt_rdata,
  output logic             err_rd_ovf,
`ifdef AXI_PMU_WR_LAT_EN
  output logic             err_wr_ovf,
  output logic             err_wr_unf,
`endif
  output logic             err_rd_unf
);

  localparam int LVL_W = $clog2(OUTST_DEPTH) + 1;
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic [LVL_W-1:0]        LVL_MAX = '1;
  localparam logic signed [LVL_W:0]   WP_MAX  = {1'b0, {LVL_W{1'b1}}};
  localparam logic signed [LVL_W:0]   WP_MIN  = {1'b1, {LVL_W{1'b0}}};

  logic ar_hs, r_hs, rl_hs, aw_hs, w_hs, wl_hs, b_hs;

  assign ar_hs = mon_axi.arvalid & mon_axi.arready;
  assign r_hs  = mon_axi.rvalid & mon_axi.rready;
  assign rl_hs = r_hs & mon_axi.rlast;
  assign aw_hs = mon_axi.awvalid & mon_axi.awready;
  assign w_hs  = mon_axi.wvalid & mon_axi.wready;
  assign wl_hs = w_hs & mon_axi.wlast;
  assign b_hs  = mon_axi.bvalid & mon_axi.bready;

  logic [TS_W-1:0]         ts;
  logic [LVL_W-1:0]        rd_out;
  logic [LVL_W-1:0]        wr_out;
  logic [LVL_W-1:0]        b_pend;
  logic signed [LVL_W:0]   w_pend;

  function automatic logic [LVL_W-1:0] lvl_next(input logic [LVL_W-1:0] cur,
                                                input logic inc, input logic dec);
    logic [LVL_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != LVL_MAX)   nxt = cur + 1'b1;
    else if (dec && !inc && cur != '0)   nxt = cur - 1'b1;
    return nxt;
  endfunction

  // Levels track the bus regardless of en/clear; responses from before a reset saturate at 0.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ts     <= '0;
      rd_out <= '0;
      wr_out <= '0;
      b_pend <= '0;
      w_pend <= '0;
    end else begin
      ts     <= ts + 1'b1;
      rd_out <= lvl_next(rd_out, ar_hs, rl_hs);
      wr_out <= lvl_next(wr_out, aw_hs, b_hs);
      b_pend <= lvl_next(b_pend, wl_hs, b_hs);
      if (aw_hs && !wl_hs && w_pend != WP_MAX)      w_pend <= w_pend + 1'b1;
      else if (wl_hs && !aw_hs && w_pend != WP_MIN) w_pend <= w_pend - 1'b1;
    end
  end

  logic [NUM_EV-1:0] ev;

  always_comb begin
    ev = '0;
    ev[CNT_RD_IDLE]      = ~mon_axi.arvalid & (rd_out == '0);
    ev[CNT_AR_STALL]     = mon_axi.arvalid & ~mon_axi.arready;
    ev[CNT_AR_HS]        = ar_hs;
    ev[CNT_RVALID_STALL] = (rd_out != '0) & ~mon_axi.rvalid;
    ev[CNT_RREADY_STALL] = mon_axi.rvalid & ~mon_axi.rready;
    ev[CNT_R_HS]         = r_hs;
    ev[CNT_WR_IDLE]      = ~mon_axi.awvalid & (wr_out == '0);
    ev[CNT_AW_STALL]     = mon_axi.awvalid & ~mon_axi.awready;
    ev[CNT_AW_HS]        = aw_hs;
    ev[CNT_WVALID_STALL] = (w_pend > 0) & ~mon_axi.wvalid;
    ev[CNT_WREADY_STALL] = mon_axi.wvalid & ~mon_axi.wready;
    ev[CNT_W_HS]         = w_hs;
    ev[CNT_BVALID_STALL] = (b_pend != '0) & ~mon_axi.bvalid;
    ev[CNT_BREADY_STALL] = mon_axi.bvalid & ~mon_axi.bready;
    ev[CNT_B_HS]         = b_hs;
  end

  logic [CNT_W-1:0] ev_cnt [NUM_EV];

  always_ff @(posedge aclk) begin
    if (areset || clear) begin
      for (int i = 0; i < NUM_EV; i++) ev_cnt[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < NUM_EV; i++)
        if (ev[i] && ev_cnt[i] != CNT_MAX) ev_cnt[i] <= ev_cnt[i] + 1'b1;
    end
  end

  logic [CNT_W-1:0] rd_sum, rd_max, rd_min;

  axi_pmu_lat_tracker #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(OUTST_DEPTH)) u_rd_trk (
    .clk     (aclk),
    .rst     (areset),
    .en      (en),
    .clear   (clear),
    .ts      (ts),
    .push    (ar_hs),
    .pop     (rl_hs),
    .lat_sum (rd_sum),
    .lat_max (rd_max),
    .lat_min (rd_min),
    .err_ovf (err_rd_ovf),
    .err_unf (err_rd_unf)
  );

`ifdef AXI_PMU_WR_LAT_EN
  logic [CNT_W-1:0] wr_sum, wr_max, wr_min;

  axi_pmu_lat_tracker #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(OUTST_DEPTH)) u_wr_trk (
    .clk     (aclk),
    .rst     (areset),
    .en      (en),
    .clear   (clear),
    .ts      (ts),
    .push    (aw_hs),
    .pop     (b_hs),
    .lat_sum (wr_sum),
    .lat_max (wr_max),
    .lat_min (wr_min),
    .err_ovf (err_wr_ovf),
    .err_unf (err_wr_unf)
  );
`endif

  logic [CNT_W-1:0] live   [NUM_CNT];
  logic [CNT_W-1:0] shadow [NUM_CNT];

  always_comb begin
    for (int i = 0; i < NUM_CNT; i++) live[i] = '0;
    for (int i = 0; i < NUM_EV; i++)  live[i] = ev_cnt[i];
    live[CNT_LAT_SUM] = rd_sum;
    live[CNT_LAT_MAX] = rd_max;
    live[CNT_LAT_MIN] = rd_min;
    live[CNT_RD_OUT]  = CNT_W'(rd_out);
    live[CNT_WR_OUT]  = CNT_W'(wr_out);
`ifdef AXI_PMU_WR_LAT_EN
    live[CNT_WR_LAT_SUM] = wr_sum;
    live[CNT_WR_LAT_MAX] = wr_max;
    live[CNT_WR_LAT_MIN] = wr_min;
`endif
  end

  // Shadow takes the registered values, so a coincident clear still yields pre-clear numbers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
    end else if (snap) begin
      for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (areset)                       cnt_rdata <= '0;
    else if (int'(cnt_sel) < NUM_CNT) cnt_rdata <= snap_sel ? shadow[cnt_sel] : live[cnt_sel];
    else                              cnt_rdata <= '0;
  end

endmodule
